dice_roller: RTL and testbench
==============================

DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable synchronized samples required to accept a button level change; legal range 2..255.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 rb_raw  input  1  raw asynchronous roll button; 1 = pressed.
REQ-005 roll_ready  input  1  downstream game FSM ready to accept a roll result.
REQ-006 roll_valid  output  1  roll result present on die1/die2/sum.
REQ-007 die1  output  3  first die value, 1..6.
REQ-008 die2  output  3  second die value, 1..6.
REQ-009 sum  output  4  die1 + die2, 2..12.
REQ-010 busy  output  1  high while state is ROLLING or VALID.

Function
REQ-011 rb_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debounced level SHALL toggle only after the synchronized level differs from it for exactly DEBOUNCE_CYCLES consecutive cycles; the stability counter SHALL clear on any cycle where the two levels match.
REQ-013 The FSM SHALL have exactly three states: IDLE, ROLLING and VALID.
REQ-014 IDLE -> ROLLING SHALL occur on the cycle after the debounced level rises; die1 and die2 SHALL load 1 on that transition.
REQ-015 In ROLLING, die1 SHALL advance by one every cycle, 1..6, wrapping 6->1; die2 SHALL advance by one only on a die1 6->1 wrap, also wrapping 6->1.
REQ-016 ROLLING -> VALID SHALL occur on the cycle after the debounced level falls; die1 and die2 SHALL freeze in that cycle.
REQ-017 With K = number of cycles spent in ROLLING, the frozen result SHALL be die1 = (K mod 6)+1 and die2 = ((K div 6) mod 6)+1.
REQ-018 sum SHALL be registered, be 4 bits wide, and update in the same cycle as the die values, so that it is always equal to die1+die2 and never overflows.
REQ-019 In VALID, roll_valid SHALL be 1, and die1/die2/sum SHALL be held stable until the handshake.
REQ-020 A handshake occurs when roll_valid and roll_ready are both 1 on a clock edge; on that edge the FSM SHALL move VALID -> IDLE and roll_valid SHALL drop the next cycle.
REQ-021 roll_valid SHALL never be asserted outside VALID; roll_ready SHALL be ignored outside VALID.
REQ-022 A debounced press arriving while in VALID SHALL be ignored, including when it coincides with the handshake cycle.
REQ-023 After a handshake, a new roll SHALL require a fresh debounced rising edge; a level still held high SHALL NOT start a roll.
REQ-024 die1/die2/sum SHALL retain their last values in IDLE.

Reset
REQ-025 On reset, the state SHALL be IDLE, roll_valid=0, busy=0, die1=1, die2=1, sum=2.
REQ-026 On reset, the synchronizer flops, debounced level and stability counter SHALL clear to 0.
REQ-027 Reset SHALL take priority over every other event, and asserting it mid-ROLLING or mid-VALID SHALL discard the roll in progress.
REQ-028 If the button is held through reset release, no roll SHALL start until it is released and pressed again.

Structure
REQ-029 Package dice_pkg SHALL hold:
- the state enumeration (IDLE, ROLLING, VALID);
- constants DIE_MIN=1, DIE_MAX=6, SUM_W=4;
- these are shared with the game FSM.
REQ-030 Synchronizer plus debounce SHALL be the single sub-module button_debounce (parameter DEBOUNCE_CYCLES, output a one-cycle rise pulse, a one-cycle fall pulse and the level); the counters and FSM stay in dice_roller.

Verification (DEBOUNCE_CYCLES=4, roll_ready=1 unless stated)
REQ-031 Press held so that K=7 -> die1=2, die2=2, sum=4, roll_valid for exactly 1 cycle.
REQ-032 K=35 -> die1=6, die2=6, sum=12; K=36 -> die1=1, die2=1, sum=2 (wrap check).
REQ-033 Bounce pulses of 1, 2 and 3 cycles on rb_raw while in IDLE -> no state change, busy=0 throughout.
REQ-034 roll_ready=0 for 10 cycles after VALID, with a second press during that window -> roll_valid and the values are stable for 10 cycles, one handshake occurs, and no second roll starts.
REQ-035 reset asserted for 1 cycle in mid-ROLLING -> next cycle IDLE, die1=1, die2=1, sum=2, roll_valid=0; with the button still held, no roll starts until re-press.

Source files
------------

// File: rtl/dice_pkg.sv
// dice_pkg: FSM states, die and sum constants, and the face-advance helper,
// shared by the dice roller and the downstream game FSM.
package dice_pkg;
   typedef enum logic [1:0] {IDLE, ROLLING, VALID} state_t;
   localparam logic [2:0] DIE_MIN = 3'd1;
   localparam logic [2:0] DIE_MAX = 3'd6;
   localparam int SUM_W = 4;
   function automatic logic [2:0] next_face(input logic [2:0] f);
      return (f == DIE_MAX) ? DIE_MIN : f + 3'd1;
   endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchronizer and stability-counter debounce for the roll button,
// producing the debounced level and one-cycle rise/fall pulses.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);
   logic       r_sync1, r_sync2, r_level, r_rise, r_fall, r_armed;
   logic [7:0] r_cnt;
   logic [1:0] r_warm;
   logic       w_hit;
   assign w_hit   = (r_sync2 != r_level) && (r_cnt == 8'(DEBOUNCE_CYCLES - 1));
   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;
   // A button still held once the synchronizer has refilled after reset leaves
   // rise pulses disarmed until a debounced release is seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_warm  <= '0;
         r_armed <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_cnt   <= (r_sync2 == r_level || w_hit) ? '0 : r_cnt + 8'd1;
         r_level <= w_hit ? r_sync2 : r_level;
         r_rise  <= w_hit && r_sync2 && r_armed;
         r_fall  <= w_hit && !r_sync2;
         r_warm  <= (r_warm == 2'd3) ? r_warm : r_warm + 2'd1;
         r_armed <= r_armed || (w_hit && !r_sync2) || (r_warm == 2'd2 && !r_sync2);
      end
   end
endmodule

// File: rtl/dice_roller.sv
// dice_roller: two-die roller; dice spin while the debounced button is held and freeze on
// release, the result being offered on a valid/ready handshake.
module dice_roller
   import dice_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rb_raw,
   input  logic             roll_ready,
   output logic             roll_valid,
   output logic [2:0]       die1,
   output logic [2:0]       die2,
   output logic [SUM_W-1:0] sum,
   output logic             busy
);
   state_t           r_state;
   logic [2:0]       r_die1, r_die2;
   logic [SUM_W-1:0] r_sum;
   logic             r_valid, r_busy;
   logic             w_level, w_rise, w_fall;
   logic [2:0]       w_d1_nxt, w_d2_nxt;
   logic [SUM_W-1:0] w_sum_nxt;
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (rb_raw),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );
   always_comb begin
      w_d1_nxt  = next_face(r_die1);
      w_d2_nxt  = (r_die1 == DIE_MAX) ? next_face(r_die2) : r_die2;
      w_sum_nxt = SUM_W'(w_d1_nxt) + SUM_W'(w_d2_nxt);
   end
   assign roll_valid = r_valid;
   assign busy       = r_busy;
   assign die1       = r_die1;
   assign die2       = r_die2;
   assign sum        = r_sum;
   // The releasing cycle still advances, so K cycles in ROLLING give K advances from 1/1.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_die1  <= DIE_MIN;
         r_die2  <= DIE_MIN;
         r_sum   <= SUM_W'(2);
      end else begin
         case (r_state)
            IDLE: if (w_rise && w_level) begin
               r_state <= ROLLING;
               r_busy  <= 1'b1;
               r_die1  <= DIE_MIN;
               r_die2  <= DIE_MIN;
               r_sum   <= SUM_W'(2);
            end
            ROLLING: begin
               r_die1 <= w_d1_nxt;
               r_die2 <= w_d2_nxt;
               r_sum  <= w_sum_nxt;
               if (w_fall) begin
                  r_state <= VALID;
                  r_valid <= 1'b1;
               end
            end
            VALID: if (roll_ready) begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dice_roller.sv
// tb_dice_roller: vector table plus random holds against a hold-length model
// (K equals the number of cycles the button is held), and reset/bounce sequences.
module tb_dice_roller;
   localparam int N = 4;
   logic       clk, reset, rb_raw, roll_ready, roll_valid, busy;
   logic [2:0] die1, die2;
   logic [3:0] sum;
   int         errors = 0;
   int         checks = 0;

   dice_roller #(.DEBOUNCE_CYCLES(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .rb_raw     (rb_raw),
      .roll_ready (roll_ready),
      .roll_valid (roll_valid),
      .die1       (die1),
      .die2       (die2),
      .sum        (sum),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         hold;
      int         rdelay;
      bit         press2;
      logic [2:0] d1;
      logic [2:0] d2;
      logic [3:0] s;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic do_roll(input int hold, input int rdelay, input bit press2,
                          input logic [2:0] e1, input logic [2:0] e2, input logic [3:0] es,
                          input string tag);
      int  waited;
      bit  stable, rolled;
      roll_ready = (rdelay == 0);
      rb_raw = 1'b1;
      repeat (hold) tick();
      rb_raw = 1'b0;
      waited = 0;
      while (!roll_valid && waited < 60) begin
         tick();
         waited++;
      end
      chk({tag, "_valid"}, roll_valid, 1);
      chk({tag, "_die1"}, die1, e1);
      chk({tag, "_die2"}, die2, e2);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_busy"}, busy, 1);
      if (rdelay > 0) begin
         stable = 1'b1;
         for (int i = 0; i < rdelay; i++) begin
            rb_raw = press2 && i >= 1 && i < 7;
            tick();
            stable &= roll_valid && die1 == e1 && die2 == e2 && sum == es;
         end
         rb_raw = 1'b0;
         chk({tag, "_held"}, stable, 1);
         roll_ready = 1'b1;
      end
      tick();
      chk({tag, "_valid_drop"}, roll_valid, 0);
      rolled = 1'b0;
      repeat (20) begin
         tick();
         rolled |= busy | roll_valid;
      end
      chk({tag, "_no_reroll"}, rolled, 0);
      chk({tag, "_retain_sum"}, sum, es);
   endtask

   vec_t vecs[6];

   initial begin
      bit seen;
      int h;
      vecs[0] = '{7, 0, 0, 3'd2, 3'd2, 4'd4};
      vecs[1] = '{35, 0, 0, 3'd6, 3'd6, 4'd12};
      vecs[2] = '{36, 0, 0, 3'd1, 3'd1, 4'd2};
      vecs[3] = '{4, 0, 0, 3'd5, 3'd1, 4'd6};
      vecs[4] = '{12, 2, 0, 3'd1, 3'd3, 4'd4};
      vecs[5] = '{9, 10, 1, 3'd4, 3'd2, 4'd6};
      rb_raw = 1'b0;
      roll_ready = 1'b1;
      reset = 1'b1;
      repeat (3) tick();
      chk("rst_valid", roll_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_die1", die1, 1);
      chk("rst_die2", die2, 1);
      chk("rst_sum", sum, 2);
      reset = 1'b0;
      repeat (5) tick();

      for (int len = 1; len <= 3; len++) begin
         seen = 1'b0;
         rb_raw = 1'b1;
         repeat (len) begin
            tick();
            seen |= busy;
         end
         rb_raw = 1'b0;
         repeat (8) begin
            tick();
            seen |= busy;
         end
         chk($sformatf("bounce_%0d", len), seen, 0);
      end

      foreach (vecs[i])
         do_roll(vecs[i].hold, vecs[i].rdelay, vecs[i].press2,
                 vecs[i].d1, vecs[i].d2, vecs[i].s, $sformatf("vec%0d", i));

      rb_raw = 1'b1;
      repeat (12) tick();
      chk("mid_roll_busy", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_rst_busy", busy, 0);
      chk("mr_rst_valid", roll_valid, 0);
      chk("mr_rst_die1", die1, 1);
      chk("mr_rst_die2", die2, 1);
      chk("mr_rst_sum", sum, 2);
      seen = 1'b0;
      repeat (25) begin
         tick();
         seen |= busy;
      end
      rb_raw = 1'b0;
      repeat (15) begin
         tick();
         seen |= busy;
      end
      chk("held_no_roll", seen, 0);
      do_roll(9, 0, 0, 3'd4, 3'd2, 4'd6, "repress");

      for (int r = 0; r < 8; r++) begin
         logic [2:0] m1, m2;
         h  = $urandom_range(N, 80);
         m1 = 3'(h % 6 + 1);
         m2 = 3'((h / 6) % 6 + 1);
         do_roll(h, $urandom_range(0, 3), 0, m1, m2, 4'(m1) + 4'(m2), $sformatf("rnd%0d_k%0d", r, h));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
